// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: address width, jump opcode
// and the fetch sequencer state encoding.
package instruction_fetch_unit_pkg;

   localparam int ADDR_W = 8;
   localparam logic [5:0] J_OPCODE = 6'b000010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Unconditional jumps are recognised purely by the top opcode field.
   function automatic logic is_jump(input logic [5:0] opcode);
      return opcode == J_OPCODE;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational next-PC selection: a redirect beats everything, a captured jump
// replaces the PC with its low byte, any other capture steps by one.
module next_pc_mux
   import instruction_fetch_unit_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic              capture,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic [ADDR_W-1:0] next_pc
);

   // Without a capture or redirect the PC simply holds (stall, end of program).
   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = redirect_target;
      end else if (capture) begin
         next_pc = jump ? jump_target : pc + 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the program from RESET_PC to PROG_LEN, hands each
// word to decode through a single-entry registered stage, and follows jumps/redirects.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PROG_LEN = 8'd22,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'd0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              imem_memread,
   output logic [ADDR_W-1:0] imem_address,
   input  logic [31:0]       imem_readdata,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              done
);

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mux_pc;
   logic              running;
   logic              at_end;
   logic              take_redirect;
   logic              capture;
   logic              restart;

   assign running       = (state == RUN);
   assign at_end        = (pc == PROG_LEN);
   assign take_redirect = running && redirect;
   assign capture       = running && !redirect && !at_end && (!instr_valid || instr_ready);
   assign restart       = !running && start;

   assign imem_memread  = running;
   assign imem_address  = pc;
   assign done          = (state == DONE);

   next_pc_mux u_next_pc_mux (
      .pc              (pc),
      .capture         (capture),
      .jump            (is_jump(imem_readdata[31:26])),
      .jump_target     (imem_readdata[ADDR_W-1:0]),
      .redirect        (take_redirect),
      .redirect_target (redirect_target),
      .next_pc         (mux_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A redirect landing on PROG_LEN is only judged at the following edge.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (!redirect && at_end) next_state = DONE;
         DONE:    if (start) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= 32'h0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (restart) begin
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
      end else begin
         pc <= mux_pc;
         if (take_redirect) begin
            instr_valid <= 1'b0;
         end else if (capture) begin
            instr       <= imem_readdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
         end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by a
// randomized phase, all compared against a cycle-level reference model of the fetch rules.
module tb_instruction_fetch_unit;

   localparam logic [7:0] PL = 8'd22;
   localparam logic [7:0] RP = 8'd0;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        imem_memread;
   logic [7:0]  imem_address;
   logic [31:0] imem_readdata;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_target;
   logic        done;

   logic [31:0] mem [256];

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 = waiting for start, 1 = fetching, 2 = finished
   int          m_mode;
   logic [7:0]  m_pc;
   logic [7:0]  m_ipc;
   logic [31:0] m_instr;
   logic        m_valid;

   always #5 clk = ~clk;

   assign imem_readdata = mem[imem_address];

   instruction_fetch_unit #(.PROG_LEN(PL), .RESET_PC(RP)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .imem_memread    (imem_memread),
      .imem_address    (imem_address),
      .imem_readdata   (imem_readdata),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .done            (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_mode  = 0;
      m_pc    = RP;
      m_ipc   = 8'h0;
      m_instr = 32'h0;
      m_valid = 1'b0;
   endtask

   // One clock edge of the fetch rules, applied to the inputs presented this cycle.
   task automatic modelStep(input logic st, input logic rdy, input logic rd, input logic [7:0] tgt);
      logic [31:0] w;
      w = mem[m_pc];
      if (m_mode == 1) begin
         if (rd) begin
            m_pc    = tgt;
            m_valid = 1'b0;
         end else if (m_pc == PL) begin
            m_mode = 2;
            if (m_valid && rdy) m_valid = 1'b0;
         end else if (!m_valid || rdy) begin
            m_instr = w;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = (w[31:26] == 6'b000010) ? w[7:0] : m_pc + 8'd1;
         end
      end else if (st) begin
         m_mode  = 1;
         m_pc    = RP;
         m_valid = 1'b0;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic checkOutput(input string tag);
      chk({tag, ".addr"},    32'(imem_address), 32'(m_pc));
      chk({tag, ".memread"}, 32'(imem_memread), 32'(m_mode == 1));
      chk({tag, ".done"},    32'(done),         32'(m_mode == 2));
      chk({tag, ".valid"},   32'(instr_valid),  32'(m_valid));
      chk({tag, ".ipc"},     32'(instr_pc),     32'(m_ipc));
      chk({tag, ".instr"},   instr,             m_instr);
   endtask

   task automatic applyStimulus(input logic st, input logic rdy, input logic rd, input logic [7:0] tgt);
      @(negedge clk);
      start           = st;
      instr_ready     = rdy;
      redirect        = rd;
      redirect_target = tgt;
      modelStep(st, rdy, rd, tgt);
      @(posedge clk);
      #1;
      checkOutput("step");
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      redirect = 1'b0;
      #1;
      modelReset();
      checkOutput("reset");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int   n;
      logic saw7;
      logic [31:0] w;

      reset = 1'b1;
      start = 1'b0;
      instr_ready = 1'b0;
      redirect = 1'b0;
      redirect_target = 8'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h20020000 | 32'(i);
      mem[0] = 32'h20020020;
      mem[9] = 32'h08000002;
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkOutput("por");
      @(negedge clk);
      reset = 1'b0;

      // first fetch latency
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h0);
      chk("start_addr", 32'(imem_address), 32'd0);
      chk("start_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
      chk("first_instr", instr, 32'h20020020);
      chk("first_pc", 32'(instr_pc), 32'd0);
      chk("first_valid", 32'(instr_valid), 32'd1);
      chk("first_addr", 32'(imem_address), 32'd1);

      // stall with instr_pc = 4
      n = 0;
      while (!(m_valid && m_ipc == 8'd4) && n < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
         n++;
      end
      chk("reach4", 32'(instr_pc), 32'd4);
      repeat (3) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h0);
         chk("stall_pc", 32'(instr_pc), 32'd4);
         chk("stall_addr", 32'(imem_address), 32'd5);
         chk("stall_instr", instr, 32'h20020004);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
      chk("release_pc", 32'(instr_pc), 32'd5);

      // jump at address 9 back to 2
      n = 0;
      while (!(m_valid && m_ipc == 8'd9) && n < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
         n++;
      end
      chk("jump_ipc", 32'(instr_pc), 32'd9);
      chk("jump_addr", 32'(imem_address), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
      chk("jump_nobubble_valid", 32'(instr_valid), 32'd1);
      chk("jump_nobubble_pc", 32'(instr_pc), 32'd2);
      mem[9] = 32'h20020009;

      // redirect wins over a capture at PC 7
      n = 0;
      while (m_pc != 8'd7 && n < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
         n++;
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd14);
      chk("redir_valid", 32'(instr_valid), 32'd0);
      chk("redir_addr", 32'(imem_address), 32'd14);

      // run to the end of the program
      saw7 = 1'b0;
      n = 0;
      while (m_pc != PL && n < 40) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
         if (instr_valid && instr_pc == 8'd7) saw7 = 1'b1;
         n++;
      end
      chk("never_pc7", 32'(saw7), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h0);
      chk("end_done", 32'(done), 32'd1);
      chk("end_memread", 32'(imem_memread), 32'd0);
      chk("end_last_pc", 32'(instr_pc), 32'd21);
      chk("end_hold_valid", 32'(instr_valid), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);
      chk("end_drop_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd5);
      chk("done_ignores_redirect", 32'(imem_address), 32'd22);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h0);
      chk("restart_addr", 32'(imem_address), 32'd0);
      chk("restart_memread", 32'(imem_memread), 32'd1);

      // randomized phase: random program with jumps, random handshakes and redirects
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         if ($urandom_range(0, 3) == 0) w = {6'b000010, w[25:8], 8'($urandom_range(0, 30))};
         mem[i] = w;
      end
      for (int c = 0; c < 600; c++) begin
         applyStimulus($urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 11) == 0,
                       8'($urandom_range(0, 255)));
      end

      // asynchronous reset in the middle of a stall
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h0);
      chk("prestall_valid", 32'(instr_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_instr", instr, 32'h0);
      chk("async_ipc", 32'(instr_pc), 32'd0);
      chk("async_addr", 32'(imem_address), 32'(RP));
      chk("async_done", 32'(done), 32'd0);
      chk("async_memread", 32'(imem_memread), 32'd0);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PROG_LEN, default 8'd22, first word address past the loaded program; fetch stops on reaching it.
REQ-002 Parameter RESET_PC, default 8'd0, PC value after reset and after restart.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle pulse that begins fetching from RESET_PC.
REQ-006 imem_memread  output  1  read enable to instruction memory.
REQ-007 imem_address  output  8  word address to instruction memory; always equals the PC.
REQ-008 imem_readdata  input  32  instruction word, combinationally valid in the same cycle as imem_address.
REQ-009 instr  output  32  registered instruction handed to decode.
REQ-010 instr_pc  output  8  address from which instr was fetched.
REQ-011 instr_valid  output  1  instr and instr_pc hold a live instruction.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 redirect  input  1  branch taken in a later stage; flush and refetch.
REQ-014 redirect_target  input  8  new PC when redirect=1.
REQ-015 done  output  1  fetch stopped at PROG_LEN.

Function
REQ-016 FSM states: IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE when the PC equals PROG_LEN at a clock edge with no redirect; DONE -> RUN on start.
REQ-017 imem_memread SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-018 Capture condition in RUN: (!instr_valid || instr_ready) && PC != PROG_LEN; on capture, instr <= imem_readdata, instr_pc <= PC, instr_valid <= 1.
REQ-019 Latency: a word is on instr exactly one edge after its address appears on imem_address with the capture condition true.
REQ-020 Next PC on capture: if imem_readdata[31:26] == 6'b000010 (J), then PC <= imem_readdata[7:0], with no bubble; otherwise PC <= PC+1.
REQ-021 PC arithmetic is 8-bit modulo; 8'hFF+1 wraps to 8'h00.
REQ-022 Stall: if instr_valid && !instr_ready, then instr, instr_pc, instr_valid and PC SHALL hold.
REQ-023 When instr_valid && instr_ready and no capture occurs (PC == PROG_LEN or state != RUN), instr_valid <= 0.
REQ-024 redirect in RUN has priority over capture and stall: PC <= redirect_target, instr_valid <= 0, and the word on imem_readdata that cycle is discarded.
REQ-025 redirect in IDLE or DONE SHALL be ignored.
REQ-026 start in RUN SHALL be ignored; start in IDLE or DONE loads PC <= RESET_PC and clears instr_valid.
REQ-027 A redirect_target of PROG_LEN or greater is legal; the DONE check of REQ-016 applies to it on the next edge.

Reset
REQ-028 On reset: state=IDLE, PC=RESET_PC, instr=32'h0, instr_pc=8'h0, instr_valid=0, done=0, imem_memread=0.
REQ-029 Reset asserted mid-RUN SHALL abort at once, including a pending stall; no partial capture survives.

Structure
REQ-030 Shared package SHALL hold the J opcode constant 6'b000010, the 8-bit address width and the FSM state encoding.
REQ-031 Next-PC selection (pc+1 / jump / redirect) SHALL be a combinational sub-module next_pc_mux; all registers stay in instruction_fetch_unit.

Verification
REQ-032 Reset, then start with instr_ready=1 and word 0x20020020 at address 0 -> one edge later instr=0x20020020, instr_pc=0, instr_valid=1, imem_address=1.
REQ-033 Word 0x08000002 at address 9 fetched -> next imem_address=2, with no invalid cycle between instr_pc=9 and instr_pc=2.
REQ-034 instr_ready=0 for 3 cycles while valid at instr_pc=4 -> instr, instr_pc=4 and imem_address=5 hold; release -> instr_pc=5 on the next edge.
REQ-035 redirect=1, redirect_target=8'd14 in the same cycle as a capture at PC=7 -> instr_valid=0 and imem_address=14 next cycle; PC 7 is never presented.
REQ-036 Sequential run to PROG_LEN=22 -> last instr_pc=21, then done=1, imem_memread=0 and instr_valid drops after acceptance; start -> imem_address=0.
REQ-037 reset pulsed asynchronously mid-stall -> all outputs reach REQ-028 values before the next clock edge.
